// File: rtl/call_driver.sv
// call_driver: caller side of the start/done function-call handshake.
// Takes operand pairs on a valid/ready request port, issues one call at a
// time to a single callee, waits for its done (with an optional timeout) and
// queues each result in a first-word fall-through FIFO.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready/req_a/b  operand request port
//   callee_start/a/b             one-cycle call pulse and operands to callee
//   callee_result/done           callee completion (pulse or level)
//   res_valid/res_ready/res_data result FIFO head
//   busy                         not idle
//   err_timeout                  sticky timeout-abort flag
module call_driver #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             callee_start,
    output logic [WIDTH-1:0] callee_a,
    output logic [WIDTH-1:0] callee_b,
    input  logic [WIDTH-1:0] callee_result,
    input  logic             callee_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [TW-1:0]    tcnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             hs, push, pop;

    // A slot is reserved at admission: only one call is ever in flight and
    // the FIFO can only shrink meanwhile, so the WAIT push never overflows.
    assign req_ready = (state == IDLE) && (count < CW'(DEPTH));
    assign hs        = req_valid && req_ready;
    assign push      = (state == WAIT) && callee_done;
    assign pop       = res_valid && res_ready;
    assign res_valid = (count != '0);
    assign res_data  = res_valid ? mem[rptr] : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            callee_start <= 1'b0;
            callee_a     <= '0;
            callee_b     <= '0;
            err_timeout  <= 1'b0;
            tcnt         <= '0;
        end else begin
            callee_start <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    callee_a     <= req_a;
                    callee_b     <= req_b;
                    callee_start <= 1'b1;   // high for the single ISSUE cycle
                    state        <= ISSUE;
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (callee_done) begin
                        // done beats a simultaneous timeout
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (TIMEOUT != 0 && (tcnt + TW'(1)) == TW'(TIMEOUT)) begin
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage is not reset; res_data is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= callee_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_call_driver.sv
module tb_call_driver;
    localparam int W = 32, D = 4, TO = 16;

    logic         clk = 1'b0;
    logic         reset, req_valid, req_ready, callee_start, callee_done;
    logic [W-1:0] req_a, req_b, callee_a, callee_b, callee_result, res_data;
    logic         res_valid, res_ready, busy, err_timeout;

    call_driver #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .callee_start(callee_start),
        .callee_a(callee_a), .callee_b(callee_b), .callee_result(callee_result),
        .callee_done(callee_done), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .err_timeout(err_timeout));

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- callee model: (a+b)^2, configurable latency ----------
    logic         cd_reg = 1'b0, force_done = 1'b0;
    logic [W-1:0] cres = '0;
    int  cal_lat = 2, cal_hold = 1;
    bit  cal_never = 0, cal_rand = 0;
    bit  pend = 0;
    int  rem = 0, hl = 0;
    logic [W-1:0] r_hold = '0, sum;
    assign callee_done   = cd_reg | force_done;
    assign callee_result = cres;

    // done is asserted in the (lat+1)-th cycle after the start pulse
    always @(posedge clk) begin
        if (callee_start) begin
            pend   = 1;
            rem    = cal_rand ? int'($urandom_range(0, 20)) : cal_lat;
            sum    = callee_a + callee_b;
            r_hold = sum * sum;
        end
        if (pend && !cal_never) begin
            if (rem == 0) begin pend = 0; hl = cal_hold; end
            else rem--;
        end
        if (hl > 0) begin cd_reg <= 1'b1; cres <= r_hold; hl--; end
        else cd_reg <= 1'b0;
    end

    // ---------------- behavioural reference (cycle timestamps) -------------
    int           cyc = 0;
    int           hs_cyc = -1;        // cycle of accepted request, -1 = none
    logic [W-1:0] q[$];
    logic [W-1:0] m_a = '0, m_b = '0;
    bit           m_err = 0;
    // observations of the DUT, used only as "actual" values
    int           starts[$];
    logic [W-1:0] popped[$];
    int           nhs = 0, err_rise = -1;
    bit           err_prev = 0;

    always @(posedge clk) begin
        if (callee_start) starts.push_back(cyc);
        if (res_valid && res_ready) popped.push_back(res_data);
        if (req_valid && req_ready) nhs++;
        if (err_timeout && !err_prev) err_rise = cyc;
        err_prev = err_timeout;

        if (reset) begin
            q.delete(); hs_cyc = -1; m_a = '0; m_b = '0; m_err = 0;
        end else begin
            if (q.size() > 0 && res_ready) void'(q.pop_front());
            if (hs_cyc < 0) begin
                if (req_valid && q.size() + (res_ready ? 0 : 0) < D + 0 && admit_ok())
                    begin hs_cyc = cyc; m_a = req_a; m_b = req_b; end
            end else if (cyc >= hs_cyc + 2) begin
                if (callee_done) begin
                    q.push_back(callee_result); hs_cyc = -1;
                end else if (cyc - (hs_cyc + 2) + 1 == TO) begin
                    m_err = 1; hs_cyc = -1;
                end
            end
        end
        cyc++;
    end

    // admission depends on the occupancy at the start of the cycle
    int occ_start = 0;
    function automatic bit admit_ok();
        return occ_start < D;
    endfunction
    always @(negedge clk) occ_start = q.size();

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", {31'b0, busy}, {31'b0, hs_cyc >= 0});
            chk("req_ready", {31'b0, req_ready}, {31'b0, hs_cyc < 0 && q.size() < D});
            chk("callee_start", {31'b0, callee_start}, {31'b0, hs_cyc >= 0 && cyc == hs_cyc + 1});
            chk("callee_a", callee_a, m_a);
            chk("callee_b", callee_b, m_b);
            chk("res_valid", {31'b0, res_valid}, {31'b0, q.size() > 0});
            if (q.size() > 0) chk("res_data", res_data, q[0]);
            chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic try_send(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int bound, output bit ok);
        req_valid = 1'b1; req_a = a; req_b = b; ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!ok) @(posedge clk);
        #0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        try_send(a, b, 100, ok);
        chk("send_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && !res_valid) begin done = 1; break; end
        end
        chk("wait_idle_bound", {31'b0, done}, 32'd1);
        tick(1);
    endtask

    // ---------------- directed + random test sequence ----------------------
    initial begin
        bit ok;
        int h0;
        reset = 1; req_valid = 0; req_a = '0; req_b = '0; res_ready = 0;
        tick(3);
        reset = 0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_callee_a", callee_a, 32'd0);
        chk("rst_err", {31'b0, err_timeout}, 32'd0);
        tick(1);

        // basic calls
        res_ready = 1; cal_lat = 2; popped.delete();
        send(32'd1, 32'd2);
        send(32'd7, 32'd4);
        wait_idle();
        chk("t1_count", popped.size(), 32'd2);
        if (popped.size() == 2) begin
            chk("t1_r0", popped[0], 32'd9);
            chk("t1_r1", popped[1], 32'd121);
        end

        // FIFO full back-pressure
        res_ready = 0; popped.delete(); h0 = nhs;
        for (int i = 0; i < 6; i++) try_send(W'(i + 1), W'(i + 2), 30, ok);
        chk("t2_handshakes", nhs - h0, 32'd4);
        chk("t2_ready_low", {31'b0, req_ready}, 32'd0);
        res_ready = 1; tick(1); res_ready = 0;
        send(32'd5, 32'd6);
        res_ready = 1;
        wait_idle();
        chk("t2_count", popped.size(), 32'd5);
        if (popped.size() == 5) begin
            chk("t2_r0", popped[0], 32'd9);
            chk("t2_r3", popped[3], 32'd81);
            chk("t2_r4", popped[4], 32'd121);
        end

        // timeout
        popped.delete(); cal_never = 1;
        send(32'd9, 32'd9);
        wait_idle();
        chk("t3_err", {31'b0, err_timeout}, 32'd1);
        chk("t3_rise", err_rise - starts[$], 32'd17);
        chk("t3_nopush", popped.size(), 32'd0);
        cal_never = 0; pend = 0;
        send(32'd2, 32'd3);
        wait_idle();
        chk("t3_r", popped.size() == 1 ? popped[0] : 32'hx, 32'd25);
        chk("t3_err_sticky", {31'b0, err_timeout}, 32'd1);

        // done held high in IDLE/ISSUE, and as a 5-cycle level in WAIT
        popped.delete(); cal_lat = 3; force_done = 1;
        tick(3);
        send(32'd4, 32'd4);
        tick(0); @(posedge clk); #1; force_done = 0;
        wait_idle();
        chk("t4_ignored", popped.size(), 32'd1);
        if (popped.size() == 1) chk("t4_r", popped[0], 32'd64);
        popped.delete(); cal_lat = 1; cal_hold = 5;
        send(32'd1, 32'd1);
        wait_idle(); tick(8);
        chk("t4_level_once", popped.size(), 32'd1);
        cal_hold = 1;

        // overflow and 3-cycle period
        popped.delete(); cal_lat = 0;
        send(32'hFFFF_FFFF, 32'd1);
        wait_idle();
        chk("t5_overflow", popped.size() == 1 ? popped[0] : 32'hx, 32'd0);
        send(32'd1, 32'd1); send(32'd2, 32'd2); send(32'd3, 32'd3);
        wait_idle();
        chk("t5_period1", starts[$] - starts[$-1], 32'd3);
        chk("t5_period2", starts[$-1] - starts[$-2], 32'd3);

        // reset in WAIT with two results queued
        popped.delete(); res_ready = 0; cal_lat = 2;
        send(32'd1, 32'd1); send(32'd2, 32'd2);
        cal_lat = 8;
        send(32'd3, 32'd3);
        tick(3);
        chk("t6_pre_busy", {31'b0, busy}, 32'd1);
        reset = 1; @(posedge clk); #1; reset = 0; res_ready = 1;
        @(negedge clk);
        chk("t6_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_start", {31'b0, callee_start}, 32'd0);
        chk("t6_err", {31'b0, err_timeout}, 32'd0);
        tick(15);
        chk("t6_late_done", popped.size(), 32'd0);

        // randomized traffic
        cal_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_a = $urandom(); req_b = $urandom();
            res_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 0; req_valid = 0; res_ready = 1; cal_rand = 0;
        tick(40);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "simulation time bound");
    end
endmodule

// File: doc/call_driver.md
Name: call_driver

Overview:
- Caller side of the start/done function-call handshake used by our generated compute blocks, such as the (a+b)^2 unit with ports a, b, start, result, done.
- Accepts operand pairs over a valid/ready request port and issues one call at a time to an attached callee.
- Waits for the callee's done, with a timeout, and queues each result in an internal FIFO drained over a valid/ready result port.
- Sits between upstream stream logic and any single callee instance.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DEPTH, 4, result FIFO entries; power of two, at least 2.
- TIMEOUT, 1024, maximum cycles spent in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operand pair is valid.
- req_ready  out  1  driver accepts the pair this cycle.
- req_a  in  WIDTH  first operand.
- req_b  in  WIDTH  second operand.
- callee_start  out  1  one-cycle call pulse to the callee.
- callee_a  out  WIDTH  operand a to the callee.
- callee_b  out  WIDTH  operand b to the callee.
- callee_result  in  WIDTH  callee result.
- callee_done  in  1  callee completion; pulse or level accepted.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer takes the FIFO head.
- res_data  out  WIDTH  FIFO head value.
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky flag, set on any timeout abort.

Behaviour:
- Reset values: state IDLE; callee_start 0; callee_a and callee_b 0; FIFO empty, so res_valid 0 and res_data 0; busy 0; err_timeout 0; timeout counter 0.
- Reset applies at any point, including during ISSUE or WAIT: in-flight call and queued results are discarded, callee_start is low the next cycle. The driver never resets the callee.
- req_ready = (state==IDLE) && (fifo_count < DEPTH).
  - Request handshake is req_valid && req_ready.
  - Admission reserves a FIFO slot. No pop can be needed before the corresponding push, so a push from WAIT always succeeds.
- State machine:
  - IDLE: on request handshake, register req_a/req_b into callee_a/callee_b and go to ISSUE. callee_done in IDLE is ignored.
  - ISSUE: exactly one cycle; callee_start=1; clear timeout counter; go to WAIT. callee_done in ISSUE is ignored, since the callee registers start.
  - WAIT, callee_done=1: push callee_result into the FIFO that cycle, then go to IDLE. callee_done=1 on the same cycle the counter reaches TIMEOUT: done wins and the result is pushed.
  - WAIT, callee_done=0: increment counter. If TIMEOUT!=0 and the incremented value equals TIMEOUT, set err_timeout, push nothing, go to IDLE.
- callee_a/callee_b stay stable from the ISSUE cycle until the next request handshake; they are not cleared after done.
- Latency and throughput:
  - Request handshake to callee_start is 1 cycle.
  - callee_done to res_valid is 1 cycle when the FIFO was empty.
  - Best-case period is 3 cycles per call when done arrives in the first WAIT cycle.
  - callee_done held as a level causes only one push, because the driver leaves WAIT.
- FIFO:
  - First-word fall-through; res_data is the head while res_valid is high.
  - Pop on res_valid && res_ready.
  - Push and pop in the same cycle are both performed, and the count is unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Popping when empty has no effect.
- Results pass through unmodified at WIDTH bits; no arithmetic is done in the driver.
- err_timeout is cleared only by reset.

Test Plan:
- Model callee computes (a+b)^2 mod 2^32, done 3 cycles after start. Requests (1,2) then (7,4) with res_ready=1 -> res_data 9 then 121, in order; callee_start one cycle each, 1 cycle after its request handshake.
- DEPTH=4, res_ready=0, 6 back-to-back requests -> exactly 4 handshakes, then req_ready stays low. One pop -> fifth request accepted. Drain all -> 5 results, in order.
- TIMEOUT=16, callee never asserts done -> err_timeout rises 16 cycles after the first WAIT cycle, no FIFO push, busy drops. A following (2,3) call to a working callee -> 25, and err_timeout stays 1.
- callee_done held high in IDLE and in ISSUE -> no push. Done held high for 5 cycles in WAIT -> exactly one result.
- Overflow operands (0xFFFFFFFF, 1) -> res_data 0x00000000. Callee with latency 0 (done in the first WAIT cycle) -> 3-cycle period across 3 back-to-back calls.
- Reset asserted in WAIT with 2 results queued -> next cycle res_valid=0, busy=0, callee_start=0, err_timeout=0. A late callee_done after reset -> no push.
